// File: rtl/systolic_tile_seq_if.sv
// Handshake/control bundle between a tile controller client and the
// systolic tile sequencer; slave = sequencer, master = its driver.
// Ports: start/mode/stall/bases in, RAM strobes, PE enables, status out.
interface systolic_tile_seq_if #(
   parameter int N  = 4,
   parameter int AW = 8,
   parameter int CW = 11
);
   localparam int NW = $clog2(N);

   logic            data_load_done;
   logic            acc_mode;
   logic            stall;
   logic [AW-1:0]   a_base;
   logic [AW-1:0]   w_base;
   logic [CW-1:0]   c_base;
   logic [AW-1:0]   ram_a_addr;
   logic [AW-1:0]   ram_w_addr;
   logic            ram_a_rden;
   logic            ram_w_rden;
   logic [N*N-1:0]  en_mac;
   logic [N*N-1:0]  clr_accum;
   logic            c_wren;
   logic [NW-1:0]   c_row;
   logic [CW-1:0]   ram_c_addr;
   logic            busy;
   logic            calc_done;

   modport master (
      output data_load_done, acc_mode, stall,
      output a_base, w_base, c_base,
      input  ram_a_addr, ram_w_addr, ram_a_rden, ram_w_rden,
      input  en_mac, clr_accum, c_wren, c_row, ram_c_addr,
      input  busy, calc_done
   );

   modport slave (
      input  data_load_done, acc_mode, stall,
      input  a_base, w_base, c_base,
      output ram_a_addr, ram_w_addr, ram_a_rden, ram_w_rden,
      output en_mac, clr_accum, c_wren, c_row, ram_c_addr,
      output busy, calc_done
   );
endinterface

// File: rtl/systolic_tile_seq.sv
// Sequencer for an N x N systolic tile: clear, K-deep skewed MAC sweep,
// row write-back, done pulse. Ports: clk, rst_n, bus (slave modport).
module systolic_tile_seq #(
   parameter int N  = 4,
   parameter int K  = 16,
   parameter int AW = 8,
   parameter int CW = 11
) (
   input logic               clk,
   input logic               rst_n,
   systolic_tile_seq_if.slave bus
);
   localparam int TW    = $clog2(K + 2*N);
   localparam int NW    = $clog2(N);
   // Last step at which the far corner PE(N-1,N-1) still consumes data.
   localparam int TLAST = K + 2*N - 2;

   typedef enum logic [2:0] {
      IDLE, CLR, CALC, WB, DONE
   } state_t;

   state_t          state, nxt;
   logic [TW-1:0]   t;
   logic [NW-1:0]   r;
   logic            acc_r;
   logic [AW-1:0]   a_base_r, w_base_r;
   logic [CW-1:0]   c_base_r;
   logic            start, go, t_end, r_end;
   int              tv;

   logic            rden;
   logic [N*N-1:0]  en;
   logic [N*N-1:0]  clr;
   logic            wren;
   logic            done;

   assign start = (state == IDLE) && bus.data_load_done;
   assign go    = !bus.stall;
   assign t_end = (t == TW'(TLAST));
   assign r_end = (r == NW'(N-1));
   assign tv    = 32'(t);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= nxt;
   end

   always_comb begin
      nxt = state;
      unique case (state)
         IDLE: if (start) nxt = CLR;
         CLR:  nxt = CALC;
         CALC: if (go && t_end) nxt = WB;
         WB:   if (go && r_end) nxt = DONE;
         DONE: nxt = IDLE;
         default: nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         t        <= '0;
         r        <= '0;
         acc_r    <= 1'b0;
         a_base_r <= '0;
         w_base_r <= '0;
         c_base_r <= '0;
      end else begin
         if (start) begin
            acc_r    <= bus.acc_mode;
            a_base_r <= bus.a_base;
            w_base_r <= bus.w_base;
            c_base_r <= bus.c_base;
         end
         if (state == CLR) begin
            t <= '0;
            r <= '0;
         end
         if (state == CALC && go && !t_end) t <= t + 1'b1;
         if (state == WB && go && !r_end)   r <= r + 1'b1;
      end
   end

   // PE(i,j) sees its first operand pair i+j cycles after the RAM
   // read of step 0, plus one cycle of RAM read latency.
   always_comb begin
      rden = 1'b0;
      en   = '0;
      clr  = '0;
      wren = 1'b0;
      done = 1'b0;
      unique case (state)
         CLR:  clr = acc_r ? '0 : '1;
         CALC: begin
            if (go) begin
               rden = (tv < K);
               for (int i = 0; i < N; i++)
                  for (int j = 0; j < N; j++)
                     en[i*N+j] = (tv >= i+j+1) && (tv <= i+j+K);
            end
         end
         WB:   wren = go;
         DONE: done = 1'b1;
         default: ;
      endcase
   end

   assign bus.ram_a_addr = a_base_r + AW'(t);
   assign bus.ram_w_addr = w_base_r + AW'(t);
   assign bus.ram_a_rden = rden;
   assign bus.ram_w_rden = rden;
   assign bus.en_mac     = en;
   assign bus.clr_accum  = clr;
   assign bus.c_wren     = wren;
   assign bus.c_row      = r;
   assign bus.ram_c_addr = c_base_r + CW'(r);
   assign bus.busy       = (state != IDLE);
   assign bus.calc_done  = done;
endmodule

// File: doc/systolic_tile_seq.md
SYSTOLIC_TILE_SEQ -- requirements
Module: systolic_tile_seq

Interface
REQ-001 SHALL have parameter N, default 4: systolic array dimension (N x N PEs), legal values 2 to 16.
REQ-002 SHALL have parameter K, default 16: reduction depth (operand words per tile), legal values 1 to 2^AW.
REQ-003 SHALL have parameter AW, default 8: operand RAM address width.
REQ-004 SHALL have parameter CW, default 11: result RAM address width.
REQ-005 SHALL have the following ports:
- clk  in  1  single clock; all logic on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- data_load_done  in  1  start request; honoured only in IDLE.
- acc_mode  in  1  sampled at start; 1 means keep accumulators from the previous tile.
- stall  in  1  freezes sequencing while high.
- a_base  in  AW  activation base address, sampled at start.
- w_base  in  AW  weight base address, sampled at start.
- c_base  in  CW  result base address, sampled at start.
- ram_a_addr  out  AW  shared activation read address.
- ram_w_addr  out  AW  shared weight read address.
- ram_a_rden  out  1  activation read enable.
- ram_w_rden  out  1  weight read enable.
- en_mac  out  N*N  per-PE MAC enable; bit i*N+j is PE(i,j).
- clr_accum  out  N*N  per-PE accumulator clear.
- c_wren  out  1  result write enable.
- c_row  out  clog2(N)  result row being written.
- ram_c_addr  out  CW  result write address.
- busy  out  1  high whenever the state is not IDLE.
- calc_done  out  1  one-cycle completion pulse.

Function
REQ-006 SHALL implement the states IDLE, CLR, CALC, WB and DONE.
REQ-007 SHALL move from IDLE to CLR on data_load_done=1, registering acc_mode, a_base, w_base and c_base in that cycle.
REQ-008 SHALL, in CLR, drive clr_accum to all ones when the registered acc_mode=0 and to all zeros otherwise, then move to CALC the next cycle (CLR ignores stall).
REQ-009 SHALL keep a CALC step counter t that starts at 0 and increments on each CALC cycle with stall=0.
REQ-010 SHALL, in CALC, assert ram_a_rden and ram_w_rden when t<K and stall=0, with ram_a_addr=a_base+t and ram_w_addr=w_base+t, each modulo 2^AW.
REQ-011 SHALL assert en_mac bit i*N+j when i+j+1 <= t <= i+j+K and stall=0 (one-cycle RAM latency plus systolic skew).
REQ-012 SHALL move from CALC to WB after the non-stalled cycle with t=K+2N-2, so CALC lasts K+2N-1 non-stalled cycles.
REQ-013 SHALL, in WB, step a row counter r from 0 to N-1 on non-stalled cycles, driving c_wren=1, c_row=r and ram_c_addr=c_base+r (modulo 2^CW); it SHALL move to DONE after r=N-1.
REQ-014 SHALL assert calc_done for exactly one cycle in DONE, then return to IDLE.
REQ-015 SHALL, while stall=1 in CALC or WB, hold t, r and the state, and force the rden outputs, en_mac and c_wren to 0; address outputs SHALL hold their values.
REQ-016 SHALL ignore data_load_done in every state except IDLE; a start in the DONE cycle SHALL be lost.
REQ-017 SHALL drive busy=1 in CLR, CALC, WB and DONE.
REQ-018 SHALL drive all enables and clears to 0 in IDLE and DONE.

Reset
REQ-019 SHALL, on rst_n=0 at any time including mid-tile, enter IDLE immediately, clear t, r and the registered bases, and drive every output to 0.
REQ-020 SHALL resume normal operation on the first rising clk edge after rst_n deasserts, with no partial write-back issued.

Verification
REQ-021 Bench SHALL cover a basic tile: N=4, K=16, a_base=0x10, acc_mode=0 -> one clr_accum cycle of all ones; rden high for 16 cycles with addresses 0x10 to 0x1F; PE(0,0) enabled for t=1..16; PE(3,3) enabled for t=7..22; 4 c_wren cycles; calc_done exactly 28 cycles after the start is sampled.
REQ-022 Bench SHALL cover accumulate mode: a second start with acc_mode=1 -> clr_accum stays 0 throughout and all other timing is identical to REQ-021.
REQ-023 Bench SHALL cover stall: stall=1 for 5 cycles at t=10 and for 2 cycles during WB r=1 -> no enable asserted while stalled, t and r frozen, calc_done delayed by exactly 7 cycles.
REQ-024 Bench SHALL cover address wrap: a_base=0xF8, K=16 -> addresses run 0xF8 to 0xFF then 0x00 to 0x07.
REQ-025 Bench SHALL cover reset mid-CALC: rst_n pulsed at t=12 -> all outputs 0 and busy=0 immediately; a new start then produces the full REQ-021 sequence.
REQ-026 Bench SHALL cover start while busy: data_load_done pulsed during CALC and during DONE -> ignored, with exactly one calc_done per honoured start.
